// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM encodings, prefix bytes, key event layout.
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t ST_WAIT_IDLE = 3'd0;
  localparam ps2_state_t ST_IDLE      = 3'd1;
  localparam ps2_state_t ST_DATA      = 3'd2;
  localparam ps2_state_t ST_PARITY    = 3'd3;
  localparam ps2_state_t ST_STOP      = 3'd4;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers are power-of-two wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 receiver folding E0/F0 prefixes into key events buffered in a FWFT FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated makes of the held key.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int IDLE_CYCLES    = 2500,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       frame_err,
  output logic       overflow
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_reg, data_sync_reg;
  logic          clk_prev_reg, ps2_clk_s, ps2_data_s, fe;
  ps2_state_t    state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [IW-1:0] idle_cnt_reg, idle_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          ext_reg, ext_next, brk_reg, brk_next;
  logic          err, push_req, frame_err_reg, overflow_reg, fifo_full, fifo_empty;
  ps2_evt_t      push_evt, head;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [9:0]    hold_reg, hold_next;  // {ext, code, held}
`endif

  assign ps2_clk_s  = clk_sync_reg[1];
  assign ps2_data_s = data_sync_reg[1];
  assign fe         = clk_prev_reg && !ps2_clk_s;
  assign push_evt   = {ext_reg, brk_reg, shift_reg};

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    idle_cnt_next = idle_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    ext_next      = ext_reg;
    brk_next      = brk_reg;
    err           = 1'b0;
    push_req      = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    hold_next     = hold_reg;
`endif
    case (state_reg)
      ST_WAIT_IDLE: begin
        if (!ps2_clk_s) begin
          idle_cnt_next = '0;
        end else if (idle_cnt_reg >= IW'(IDLE_CYCLES - 1)) begin
          idle_cnt_next = '0;
          state_next    = ST_IDLE;
        end else begin
          idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end
      ST_IDLE: begin
        if (fe && !ps2_data_s) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
          to_cnt_next  = '0;
        end
      end
      ST_DATA, ST_PARITY, ST_STOP: begin
        if (fe) begin
          to_cnt_next = '0;
          if (state_reg == ST_DATA) begin
            shift_next   = {ps2_data_s, shift_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
          end else if (state_reg == ST_PARITY) begin
            if (^{shift_reg, ps2_data_s}) state_next = ST_STOP;
            else                          err        = 1'b1;
          end else if (ps2_data_s) begin
            state_next = ST_IDLE;
            if (shift_reg == PS2_EXT) begin
              ext_next = 1'b1;
            end else if (shift_reg == PS2_BRK) begin
              brk_next = 1'b1;
            end else begin
              ext_next = 1'b0;
              brk_next = 1'b0;
              push_req = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
              if (hold_reg[0] && hold_reg[9:1] == {ext_reg, shift_reg}) begin
                if (brk_reg) hold_next = '0;
                else         push_req  = 1'b0;
              end else if (!brk_reg) begin
                hold_next = {ext_reg, shift_reg, 1'b1};
              end
`endif
            end
          end else begin
            err = 1'b1;
          end
        // Registered error output lands TIMEOUT_CYCLES after the last edge.
        end else if (to_cnt_reg >= TW'(TIMEOUT_CYCLES - 2)) begin
          err = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_WAIT_IDLE;
    endcase
    if (err) begin
      state_next    = ST_WAIT_IDLE;
      bit_cnt_next  = '0;
      shift_next    = '0;
      idle_cnt_next = '0;
      to_cnt_next   = '0;
      ext_next      = 1'b0;
      brk_next      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      clk_prev_reg  <= 1'b1;
      state_reg     <= ST_WAIT_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      idle_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      clk_prev_reg  <= ps2_clk_s;
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      idle_cnt_reg  <= idle_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      ext_reg       <= ext_next;
      brk_reg       <= brk_next;
      frame_err_reg <= err;
      overflow_reg  <= push_req && fifo_full && !evt_ready;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst) hold_reg <= '0;
    else     hold_reg <= hold_next;
  end
`endif

  ps2_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (push_evt),
    .pop   (evt_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = evt_valid ? head.code : 8'h00;
  assign evt_break = evt_valid && head.brk;
  assign evt_ext   = evt_valid && head.ext;
  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: frames, prefixes, errors, timeout, overflow, typematic, mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_key_event_ctrl;

  localparam int TO    = 2000;
  localparam int IDLE  = 200;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_ready = 1'b1;
  logic       evt_valid, evt_break, evt_ext, frame_err, overflow;
  logic [7:0] evt_code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [9:0] ev_q[$];
  int ev_cyc_q[$];
  int err_cnt = 0, err_cyc = 0, ovf_cnt = 0, ovf_cyc = 0;
  int last_fall = 0, par_fall = 0, stop_fall = 0;
  int exp_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_key_event_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .IDLE_CYCLES    (IDLE),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // Records accepted events and error/overflow pulses, away from the active edge.
  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      ev_q.push_back({evt_ext, evt_break, evt_code});
      ev_cyc_q.push_back(cyc);
    end
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (overflow) begin
      ovf_cnt = ovf_cnt + 1;
      ovf_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev_at(input int i);
    if (i < ev_q.size()) return {22'd0, ev_q[i]};
    return 32'hDEAD;
  endfunction

  function automatic int ev_cyc_at(input int i);
    if (i < ev_cyc_q.size()) return ev_cyc_q[i];
    return -1;
  endfunction

  task automatic clr();
    ev_q.delete();
    ev_cyc_q.delete();
    err_cnt = 0;
    ovf_cnt = 0;
  endtask

  // Frame bits LSB-first: start, 8 data, odd parity (optionally inverted), stop.
  task automatic send_bits(input logic [7:0] b, input bit flip, input int lo, input int hi);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip, b, 1'b0};
    $display("frame byte=%02h flip_parity=%0d bits=%0d..%0d", b, flip, lo, hi - 1);
    for (int i = lo; i < hi; i++) begin
      step();
      ps2_data = fr[i];
      wait_cycles(HALF - 1);
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == 9)  par_fall  = cyc;
      if (i == 10) stop_fall = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    wait_cycles(2 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 0, 11);
  endtask

  initial begin
    wait_cycles(5);
    @(negedge clk);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_code", {24'd0, evt_code}, 32'd0);
    check("rst_break", {31'd0, evt_break}, 32'd0);
    check("rst_ext", {31'd0, evt_ext}, 32'd0);
    step();
    rst = 1'b0;
    wait_cycles(IDLE + 50);

    // Plain make code, popped immediately.
    clr();
    send(8'h29);
    check("make29_count", ev_q.size(), 32'd1);
    check("make29_event", ev_at(0), 32'h029);
    check("make29_latency", ev_cyc_at(0), stop_fall + 3);
    check("make29_no_err", err_cnt, 32'd0);
    check("make29_drained", {31'd0, evt_valid}, 32'd0);

    // Prefix folding.
    clr();
    send(8'hF0);
    send(8'h29);
    check("brk29_count", ev_q.size(), 32'd1);
    check("brk29_event", ev_at(0), 32'h129);
    clr();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("extbrk75_count", ev_q.size(), 32'd1);
    check("extbrk75_event", ev_at(0), 32'h375);

    // Parity error, then recovery.
    clr();
    send_bits(8'h76, 1'b1, 0, 11);
    check("parity_err_pulses", err_cnt, 32'd1);
    check("parity_err_time", err_cyc, par_fall + 3);
    check("parity_no_event", ev_q.size(), 32'd0);
    wait_cycles(IDLE + 50);
    clr();
    send(8'h76);
    check("after_parity_count", ev_q.size(), 32'd1);
    check("after_parity_event", ev_at(0), 32'h076);

    // Clock stalls after five data bits.
    clr();
    send_bits(8'h5A, 1'b0, 0, 6);
    wait_cycles(TO + 50);
    check("timeout_pulses", err_cnt, 32'd1);
    check("timeout_time", err_cyc, last_fall + 2 + TO);
    check("timeout_no_event", ev_q.size(), 32'd0);
    wait_cycles(IDLE + 50);
    clr();
    send(8'h29);
    check("after_timeout_count", ev_q.size(), 32'd1);
    check("after_timeout_event", ev_at(0), 32'h029);

    // Fill the FIFO with the consumer stalled.
    step();
    evt_ready = 1'b0;
    clr();
    for (int k = 0; k < 5; k++) send(8'h15 + 8'(k));
    check("ovf_pulses", ovf_cnt, 32'd1);
    check("ovf_time", ovf_cyc, stop_fall + 3);
    @(negedge clk);
    check("full_valid", {31'd0, evt_valid}, 32'd1);
    check("full_head", {24'd0, evt_code}, 32'h15);
    wait_cycles(5);
    @(negedge clk);
    check("head_stable", {22'd0, evt_ext, evt_break, evt_code}, 32'h015);
    step();
    evt_ready = 1'b1;
    wait_cycles(8);
    check("drain_count", ev_q.size(), 32'd4);
    for (int k = 0; k < 4; k++) check("drain_order", ev_at(k), 32'h015 + k);
    check("drain_empty", {31'd0, evt_valid}, 32'd0);

    // Typematic repeats followed by release.
    clr();
    send(8'h29);
    send(8'h29);
    send(8'h29);
    send(8'hF0);
    send(8'h29);
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_n = 2;
`else
    exp_n = 4;
`endif
    check("typematic_count", ev_q.size(), exp_n);
    check("typematic_first", ev_at(0), 32'h029);
    check("typematic_last", ev_at(exp_n - 1), 32'h129);

    // Reset in the middle of a frame; the rest of that frame must be ignored.
    clr();
    send_bits(8'h76, 1'b0, 0, 4);
    step();
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    send_bits(8'h76, 1'b0, 4, 11);
    check("midrst_no_event", ev_q.size(), 32'd0);
    check("midrst_no_err", err_cnt, 32'd0);
    wait_cycles(IDLE + 50);
    clr();
    send(8'h76);
    check("after_midrst_count", ev_q.size(), 32'd1);
    check("after_midrst_event", ev_at(0), 32'h076);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
